// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM state encoding, legal prescale values, parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110
  } rx_state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Zero-extension to 32 bits leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [31:0] data, input logic par_typ);
    return par_typ ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and sample-point decode; decision at P/2, or P/2+1 with a 3-sample
// majority when UART_RX_MAJORITY_VOTE_EN is defined. No backpressure: free-running while i_run.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_run,
  input  logic                  i_rx,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  bit_value,
  output logic                  bit_dec,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_last;

  assign w_half   = i_prescale >> 1;
  assign w_last   = i_prescale - PRESCALE_W'(1);
  assign bit_done = i_run && (r_edge_cnt == w_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_edge_cnt <= '0;
    end else if (!i_run || bit_done) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // r_hist holds the samples from edge_cnt P/2-1 and P/2 when the decision lands at P/2+1.
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], i_rx};
    end
  end

  assign bit_dec   = i_run && (r_edge_cnt == w_half + PRESCALE_W'(1));
  assign bit_value = (r_hist[1] & r_hist[0]) | (r_hist[1] & i_rx) | (r_hist[0] & i_rx);
`else
  assign bit_dec   = i_run && (r_edge_cnt == w_half);
  assign bit_value = i_rx;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver (optional UART_RX_MAJORITY_VOTE_EN); result pulses one cycle after the stop decision.
// No backpressure: DATA_VALID/PAR_ERR/STP_ERR are single-cycle pulses, P_DATA holds the last good byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] w_prescale_legal;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_bad;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  w_bit_value;
  logic                  w_bit_dec;
  logic                  w_bit_done;
  logic                  w_start;
  logic                  w_last_bit;
  logic                  w_frame_end;
  logic                  w_frame_ok;

  assign Busy       = (r_state != IDLE);
  assign w_start    = (r_state == IDLE) && !RX_IN;
  assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_frame_ok = w_bit_value && !r_par_bad;
  assign w_prescale_legal = (PRESCALE == PRESCALE_W'(PRESCALE_16) ||
                             PRESCALE == PRESCALE_W'(PRESCALE_32)) ? PRESCALE
                                                                   : PRESCALE_W'(PRESCALE_8);

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .i_run      (Busy),
    .i_rx       (RX_IN),
    .i_prescale (r_prescale),
    .bit_value  (w_bit_value),
    .bit_dec    (w_bit_dec),
    .bit_done   (w_bit_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    case (r_state)
      IDLE:   if (!RX_IN) w_state_nxt = START;
      START: begin
        if (w_bit_dec && w_bit_value) begin
          w_state_nxt = IDLE;
        end else if (w_bit_done) begin
          w_state_nxt = DATA;
        end
      end
      DATA:   if (w_bit_done && w_last_bit) w_state_nxt = r_par_en ? PARITY : STOP;
      PARITY: if (w_bit_done) w_state_nxt = STOP;
      // Leave at the stop decision so a start bit right after the stop bit is not missed.
      STOP: begin
        if (w_bit_dec) begin
          w_state_nxt = IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prescale <= PRESCALE_W'(PRESCALE_8);
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_bad  <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      if (w_start) begin
        r_prescale <= w_prescale_legal;
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_par_bad  <= 1'b0;
        r_bit_cnt  <= '0;
      end
      if (r_state == DATA && w_bit_dec) begin
        r_shift <= {w_bit_value, r_shift[DATA_WIDTH-1:1]};
      end
      if (r_state == DATA && w_bit_done) begin
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
      end
      if (r_state == PARITY && w_bit_dec) begin
        r_par_bad <= (w_bit_value != calc_parity(32'(r_shift), r_par_typ));
      end
      DATA_VALID <= w_frame_end && w_frame_ok;
      PAR_ERR    <= w_frame_end && r_par_bad;
      STP_ERR    <= w_frame_end && !w_bit_value;
      if (w_frame_end && w_frame_ok) begin
        P_DATA <= r_shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit-by-bit, result pulses counted on the falling edge.
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int DEC_OFS = 3;
`else
  localparam int DEC_OFS = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int n_dv = 0, n_pe = 0, n_se = 0, dv_cyc = 0;
  int b_dv, b_pe, b_se;
  logic [7:0] dv_log [0:15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .RX_IN      (rx_in),
    .PRESCALE   (prescale),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_ERR    (par_err),
    .STP_ERR    (stp_err),
    .Busy       (busy)
  );

  always @(negedge clk) begin
    if (data_valid) begin
      if (n_dv < 16) dv_log[n_dv] = p_data;
      n_dv++;
      dv_cyc = cyc;
    end
    if (par_err) n_pe++;
    if (stp_err) n_se++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_dv = n_dv;
    b_pe = n_pe;
    b_se = n_se;
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                            input logic pb, input logic sb);
    rx_in = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      tick(p);
    end
    if (pe) begin
      rx_in = pb;
      tick(p);
    end
    stop_cyc = cyc;
    rx_in = sb;
    tick(p);
    rx_in = 1'b1;
  endtask

  task automatic check_counts(input string name, input int dv, input int pe, input int se);
    checks++;
    if ((n_dv - b_dv) !== dv || (n_pe - b_pe) !== pe || (n_se - b_se) !== se) begin
      failures++;
      $display("FAIL %s_pulses: got dv=%0d pe=%0d se=%0d expected dv=%0d pe=%0d se=%0d",
               name, n_dv - b_dv, n_pe - b_pe, n_se - b_se, dv, pe, se);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if (p_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_pdata: got %h expected 00", p_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if ({data_valid, par_err, stp_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulses: got %b expected 000", {data_valid, par_err, stp_err});
    end
    reset = 1'b1;
    tick(3);
  endtask

  task automatic test_good_parity();
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    snap();
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL good_busy_after_stop: got %b expected 0", busy);
    end
    tick(4);
    check_counts("good", 1, 0, 0);
    checks++;
    if (p_data !== 8'hA5) begin
      failures++;
      $display("FAIL good_pdata: got %h expected a5", p_data);
    end
    checks++;
    if (dv_cyc - stop_cyc !== 4 + DEC_OFS) begin
      failures++;
      $display("FAIL good_latency: got %0d expected %0d", dv_cyc - stop_cyc, 4 + DEC_OFS);
    end
  endtask

  task automatic test_parity_err();
    snap();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
    tick(4);
    check_counts("parerr", 0, 1, 0);
    checks++;
    if (p_data !== 8'hA5) begin
      failures++;
      $display("FAIL parerr_pdata_hold: got %h expected a5", p_data);
    end
  endtask

  task automatic test_stop_err();
    prescale = 6'd16; par_en = 1'b0;
    snap();
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0);
    tick(40);
    check_counts("stoperr", 0, 0, 1);
    checks++;
    if (p_data !== 8'hA5) begin
      failures++;
      $display("FAIL stoperr_pdata_hold: got %h expected a5", p_data);
    end
  endtask

  task automatic test_glitch();
    prescale = 6'd8; par_en = 1'b0;
    snap();
    rx_in = 1'b0;
    tick(2);
    rx_in = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_start: got %b expected 1", busy);
    end
    tick(3);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_before_dec: got %b expected 1", busy);
    end
    tick(DEC_OFS - 1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy_after_dec: got %b expected 0", busy);
    end
    tick(5);
    check_counts("glitch", 0, 0, 0);
    snap();
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    tick(4);
    check_counts("after_glitch", 1, 0, 0);
    checks++;
    if (p_data !== 8'h5A) begin
      failures++;
      $display("FAIL after_glitch_pdata: got %h expected 5a", p_data);
    end
  endtask

  task automatic test_illegal_prescale();
    prescale = 6'd12; par_en = 1'b0;
    snap();
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    tick(4);
    check_counts("illegal_ps", 1, 0, 0);
    checks++;
    if (p_data !== 8'hC3) begin
      failures++;
      $display("FAIL illegal_ps_pdata: got %h expected c3", p_data);
    end
  endtask

  task automatic test_config_hold();
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1;
    snap();
    fork
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
      begin
        tick(20);
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
      end
    join
    tick(4);
    check_counts("cfg_hold", 1, 0, 0);
    checks++;
    if (p_data !== 8'h3C) begin
      failures++;
      $display("FAIL cfg_hold_pdata: got %h expected 3c", p_data);
    end
  endtask

  task automatic test_back_to_back();
    prescale = 6'd32; par_en = 1'b0;
    snap();
    send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1);
    tick(4);
    check_counts("b2b", 2, 0, 0);
    checks++;
    if (dv_log[b_dv] !== 8'h00) begin
      failures++;
      $display("FAIL b2b_first: got %h expected 00", dv_log[b_dv]);
    end
    checks++;
    if (dv_log[b_dv + 1] !== 8'hFF) begin
      failures++;
      $display("FAIL b2b_second: got %h expected ff", dv_log[b_dv + 1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hFF;
    prescale = 6'd8; par_en = 1'b0;
    rx_in = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      rx_in = d[i];
      tick(8);
    end
    rx_in = d[4];
    tick(4);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy_before: got %b expected 1", busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_busy: got %b expected 0", busy);
    end
    checks++;
    if (p_data !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_pdata: got %h expected 00", p_data);
    end
    checks++;
    if ({data_valid, par_err, stp_err} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_pulses: got %b expected 000", {data_valid, par_err, stp_err});
    end
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(3);
    par_en = 1'b1; par_typ = 1'b1;
    snap();
    send_frame(8'h81, 8, 1'b1, 1'b0, 1'b1);
    tick(4);
    check_counts("rstmid_next", 1, 0, 0);
    checks++;
    if (p_data !== 8'h81) begin
      failures++;
      $display("FAIL rstmid_next_pdata: got %h expected 81", p_data);
    end
  endtask

  initial begin
    test_reset();
    test_good_parity();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_illegal_prescale();
    test_config_hold();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
